// File: rtl/apb_regbank_pkg.sv
// Shared types and constants for the APB register bank.
package apb_regbank_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } apb_state_e;

    localparam logic [31:0] ERR_DATA   = 32'hDEAD_BEEF;
    localparam int unsigned REG_STRIDE = 4;

endpackage

// File: rtl/apb_wait_ctrl.sv
// APB slave handshake FSM: IDLE/ACCESS with a programmable wait-state counter.
module apb_wait_ctrl
    import apb_regbank_pkg::*;
#(
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic PCLK,
    input  logic PRESETn,
    input  logic PSEL,
    input  logic PENABLE,
    output logic PREADY,
    output logic complete
);

    apb_state_e state_q;
    logic [3:0] cnt_q;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (PSEL && !PENABLE) begin
                        state_q <= ACCESS;
                        cnt_q   <= 4'(WAIT_STATES);
                    end
                end
                ACCESS: begin
                    // A dropped PSEL abandons the transfer without completing it.
                    if (!PSEL) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end else if (PENABLE) begin
                        if (cnt_q != 4'd0) begin
                            cnt_q <= cnt_q - 4'd1;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign PREADY   = (state_q == ACCESS) && PSEL && PENABLE && (cnt_q == 4'd0);
    assign complete = PREADY;

endmodule

// File: rtl/apb_regbank.sv
// APB register bank: byte-strobed R/W registers, read-only status slots, error decode.
module apb_regbank
    import apb_regbank_pkg::*;
#(
    parameter int unsigned        DATA_W      = 32,
    parameter int unsigned        ADDR_W      = 16,
    parameter int unsigned        NUM_REGS    = 4,
    parameter int unsigned        WAIT_STATES = 0,
    parameter logic [NUM_REGS-1:0] RO_MASK    = '0
) (
    input  logic                         PCLK,
    input  logic                         PRESETn,
    input  logic                         PSEL,
    input  logic                         PENABLE,
    input  logic                         PWRITE,
    input  logic [ADDR_W-1:0]            PADDR,
    input  logic [DATA_W-1:0]            PWDATA,
    input  logic [DATA_W/8-1:0]          PSTRB,
    output logic                         PREADY,
    output logic                         PSLVERR,
    output logic [DATA_W-1:0]            PRDATA,
    output logic [NUM_REGS*DATA_W-1:0]   reg_out,
    input  logic [NUM_REGS*DATA_W-1:0]   reg_in,
    output logic [NUM_REGS-1:0]          reg_wr_pulse
);

    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned OFS_W  = $clog2(REG_STRIDE);
    localparam int unsigned IDX_W  = ADDR_W - OFS_W;
    localparam logic [DATA_W-1:0] ERR_WORD = DATA_W'(ERR_DATA);

    logic                complete;
    logic [IDX_W-1:0]    idx;
    logic [NUM_REGS-1:0] sel;
    logic                hit_ro;
    logic                invalid;
    logic                wr_commit;
    logic [DATA_W-1:0]   rd_word;
    logic [DATA_W-1:0]   regs_q [NUM_REGS];
    logic [NUM_REGS-1:0] pulse_q;

    apb_wait_ctrl #(
        .WAIT_STATES (WAIT_STATES)
    ) u_wait_ctrl (
        .PCLK     (PCLK),
        .PRESETn  (PRESETn),
        .PSEL     (PSEL),
        .PENABLE  (PENABLE),
        .PREADY   (PREADY),
        .complete (complete)
    );

    // One-hot select; stays all-zero for misaligned or out-of-range addresses.
    always_comb begin
        idx    = PADDR[ADDR_W-1:OFS_W];
        sel    = '0;
        hit_ro = 1'b0;
        for (int i = 0; i < int'(NUM_REGS); i++) begin
            if (idx == IDX_W'(i) && PADDR[OFS_W-1:0] == '0) begin
                sel[i] = 1'b1;
                hit_ro = RO_MASK[i];
            end
        end
        invalid   = (sel == '0) || (PWRITE && hit_ro);
        wr_commit = complete && PWRITE && !invalid;
    end

    always_comb begin
        rd_word = '0;
        for (int i = 0; i < int'(NUM_REGS); i++) begin
            if (sel[i]) begin
                rd_word = RO_MASK[i] ? reg_in[i*DATA_W +: DATA_W] : regs_q[i];
            end
        end
        PRDATA  = (complete && !PWRITE) ? (invalid ? ERR_WORD : rd_word) : '0;
        PSLVERR = complete && invalid;
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                regs_q[i] <= '0;
            end
            pulse_q <= '0;
        end else begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                for (int b = 0; b < int'(STRB_W); b++) begin
                    if (wr_commit && sel[i] && !RO_MASK[i] && PSTRB[b]) begin
                        regs_q[i][8*b +: 8] <= PWDATA[8*b +: 8];
                    end
                end
            end
            pulse_q <= (wr_commit && (PSTRB != '0)) ? sel : '0;
        end
    end

    always_comb begin
        for (int i = 0; i < int'(NUM_REGS); i++) begin
            reg_out[i*DATA_W +: DATA_W] = regs_q[i];
        end
    end

    assign reg_wr_pulse = pulse_q;

endmodule

// File: doc/apb_regbank.md
APB_REGBANK -- requirements
Module: apb_regbank

Interface
REQ-001 SHALL have parameter DATA_W, default 32, data/register width; multiple of 8.
REQ-002 SHALL have parameter ADDR_W, default 16, decoded PADDR bits.
REQ-003 SHALL have parameter NUM_REGS, default 4, register count, 1..64.
REQ-004 SHALL have parameter WAIT_STATES, default 0, PREADY-low cycles per access, 0..15.
REQ-005 SHALL have parameter RO_MASK, default 0, NUM_REGS bits; bit i set = register i read-only, sourced from reg_in.
REQ-006 SHALL have port PCLK  input  1  APB clock.
REQ-007 SHALL have port PRESETn  input  1  reset; asynchronous, active-low.
REQ-008 SHALL have ports PSEL, PENABLE, PWRITE  input  1 each  APB control.
REQ-009 SHALL have port PADDR  input  ADDR_W  byte address.
REQ-010 SHALL have port PWDATA  input  DATA_W  write data.
REQ-011 SHALL have port PSTRB  input  DATA_W/8  byte-lane write strobes.
REQ-012 SHALL have ports PREADY, PSLVERR  output  1 each  transfer complete / error.
REQ-013 SHALL have port PRDATA  output  DATA_W  read data.
REQ-014 SHALL have port reg_out  output  NUM_REGS*DATA_W  flattened R/W register contents; register i at slice i.
REQ-015 SHALL have port reg_in  input  NUM_REGS*DATA_W  status values returned for RO registers.
REQ-016 SHALL have port reg_wr_pulse  output  NUM_REGS  one-cycle per-register write-commit strobe.

Function
REQ-017 Register i SHALL sit at byte offset 4*i; index = PADDR[ADDR_W-1:2]; PADDR bits above ADDR_W ignored.
REQ-018 Address SHALL be invalid if index >= NUM_REGS, PADDR[1:0] != 0, or write to RO register.
REQ-019 Controller SHALL have states IDLE and ACCESS plus 4-bit wait counter cnt.
REQ-020 IDLE->ACCESS on PSEL=1, PENABLE=0 (setup), loading cnt=WAIT_STATES.
REQ-021 In ACCESS with PSEL&PENABLE: cnt!=0 -> PREADY=0, cnt decrements; cnt==0 -> PREADY=1 (combinational), transfer completes, next state IDLE.
REQ-022 WAIT_STATES=0 SHALL give zero-wait access: PREADY=1 in first enable cycle.
REQ-023 PSEL dropping in ACCESS SHALL abort to IDLE with no register update and no pulse.
REQ-024 PREADY, PSLVERR SHALL be 0 in every cycle other than the completion cycle.
REQ-025 Valid write SHALL update, at the completion clock edge, byte lane b of register index only where PSTRB[b]=1.
REQ-026 reg_wr_pulse[index] SHALL be 1 the cycle after a valid write completion with any PSTRB bit set; 0 otherwise.
REQ-027 PSTRB=0 valid write SHALL complete with PSLVERR=0, no update, no pulse.
REQ-028 Read completion SHALL drive PRDATA = register (R/W) or reg_in slice (RO); invalid address -> 0xDEADBEEF (truncated to DATA_W) with PSLVERR=1.
REQ-029 Invalid write SHALL complete with PSLVERR=1 and change no state except FSM.
REQ-030 PRDATA SHALL be 0 outside read completion cycles.
REQ-031 Back-to-back transfers SHALL each require a setup phase; no ACCESS->ACCESS transition.

Reset
REQ-032 PRESETn low SHALL immediately force all R/W registers 0, state IDLE, cnt 0, reg_wr_pulse 0, PREADY/PSLVERR/PRDATA 0.
REQ-033 Reset mid-transfer SHALL abort with no write; first transfer after release requires fresh setup.

Structure
REQ-034 Package apb_regbank_pkg SHALL hold state enum (IDLE, ACCESS), ERR_DATA=0xDEADBEEF, REG_STRIDE=4.
REQ-035 FSM and wait counter SHALL be sub-module apb_wait_ctrl (outputs PREADY and complete strobe); decode, storage, read mux in apb_regbank.

Verification (DATA_W=32, NUM_REGS=4, WAIT_STATES=2, RO_MASK=4'b1000 unless stated)
REQ-036 Write 0x12345678 to 0x4, PSTRB=0xF -> PREADY low 2 enable cycles then high; reg 1 = 0x12345678; reg_wr_pulse=4'b0010 one cycle later.
REQ-037 Reg 1=0x12345678; write 0xAABBCCDD, PSTRB=0x5 -> reg 1 = 0x12BB56DD; read 0x4 returns it, PSLVERR=0.
REQ-038 reg_in slice 3=0xCAFEF00D; read 0xC -> 0xCAFEF00D; write 0xC -> PSLVERR=1, pulse 0.
REQ-039 Read 0x10 and 0x2 -> PRDATA=0xDEADBEEF, PSLVERR=1; write 0x10 -> no register changes.
REQ-040 WAIT_STATES=0: write 0x8 -> PREADY=1 first enable cycle; PRESETn low during WAIT_STATES=2 write -> all regs 0, no pulse.
